// File: rtl/div_hilo_ctrl.sv
// Sequencer around a combinational divider: latches operand magnitudes, waits a fixed
// settle time, then sign-corrects the {quotient, remainder} result into the HI/LO pair.
module div_hilo_ctrl #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned LATENCY = 4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic [WIDTH-1:0]   div_dividend,
    output logic [WIDTH-1:0]   div_divisor,
    input  logic [2*WIDTH-1:0] div_z,
    input  logic               mthi,
    input  logic               mtlo,
    input  logic [WIDTH-1:0]   wr_data,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               busy,
    output logic               stall,
    output logic               dz
);

    typedef enum logic [1:0] {IDLE, SETTLE, WRITE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t           state;
    logic [3:0]       count;
    logic             sign_q;
    logic             sign_r;
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;

    assign neg_a = is_signed & op_a[WIDTH-1];
    assign neg_b = is_signed & op_b[WIDTH-1];
    assign quot  = div_z[2*WIDTH-1:WIDTH];
    assign rem   = div_z[WIDTH-1:0];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state        <= IDLE;
            count        <= '0;
            sign_q       <= 1'b0;
            sign_r       <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
            hi           <= '0;
            lo           <= '0;
            dz           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A start in IDLE always takes priority over move-to writes.
                    if (start) begin
                        if (op_b != '0) begin
                            sign_q       <= neg_a ^ neg_b;
                            sign_r       <= neg_a;
                            div_dividend <= neg_a ? -op_a : op_a;
                            div_divisor  <= neg_b ? -op_b : op_b;
                            dz           <= 1'b0;
                            count        <= CNT_INIT;
                            state        <= SETTLE;
                        end else begin
                            dz <= 1'b1;
                        end
                    end else begin
                        if (mthi) hi <= wr_data;
                        if (mtlo) lo <= wr_data;
                    end
                end
                SETTLE: begin
                    if (count == '0) state <= WRITE;
                    else             count <= count - 4'd1;
                end
                WRITE: begin
                    lo    <= sign_q ? -quot : quot;
                    hi    <= sign_r ? -rem : rem;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign stall = busy | (start & (state == IDLE));

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Directed bench for div_hilo_ctrl; the bench plays the combinational divider.
module tb_div_hilo_ctrl;

    localparam int unsigned W = 32;
    localparam int unsigned L = 4;

    logic           clk = 1'b0;
    logic           clr;
    logic           start;
    logic           is_signed;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [W-1:0]   div_dividend;
    logic [W-1:0]   div_divisor;
    logic [2*W-1:0] div_z;
    logic           mthi;
    logic           mtlo;
    logic [W-1:0]   wr_data;
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;
    logic           busy;
    logic           stall;
    logic           dz;

    int checks   = 0;
    int failures = 0;
    int cyc;

    div_hilo_ctrl #(.WIDTH(W), .LATENCY(L)) dut (
        .clk          (clk),
        .clr          (clr),
        .start        (start),
        .is_signed    (is_signed),
        .op_a         (op_a),
        .op_b         (op_b),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_z        (div_z),
        .mthi         (mthi),
        .mtlo         (mtlo),
        .wr_data      (wr_data),
        .hi           (hi),
        .lo           (lo),
        .busy         (busy),
        .stall        (stall),
        .dz           (dz)
    );

    always #5 clk = ~clk;

    // Ideal unsigned divider on the magnitudes the DUT presents.
    always_comb begin
        div_z = '0;
        if (div_divisor != '0) div_z = {div_dividend / div_divisor, div_dividend % div_divisor};
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts busy cycles after the accepting edge; bounded so a stuck FSM still reports.
    task automatic wait_done(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1; is_signed = sgn; op_a = a; op_b = b;
        tick();
        start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    endtask

    initial begin
        clr = 1'b0; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
        mthi = 1'b0; mtlo = 1'b0; wr_data = '0;
        #12;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_dz", {31'b0, dz}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        clr = 1'b1;
        tick();

        // Unsigned 100 / 7
        start = 1'b1; op_a = 32'd100; op_b = 32'd7; is_signed = 1'b0;
        #1;
        chk("u_stall_start", {31'b0, stall}, 32'h1);
        tick();
        start = 1'b0;
        chk("u_busy1", {31'b0, busy}, 32'h1);
        chk("u_stall_busy", {31'b0, stall}, 32'h1);
        chk("u_dividend", div_dividend, 32'd100);
        chk("u_divisor", div_divisor, 32'd7);
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            if (cyc == L + 1) chk("u_lo_before_write", lo, 32'h0);
            tick();
        end
        chk("u_busy_cycles", cyc, L + 1);
        chk("u_lo", lo, 32'd14);
        chk("u_hi", hi, 32'd2);
        chk("u_dividend_hold", div_dividend, 32'd100);

        // Unsigned with MSB set must not be negated
        issue(1'b0, 32'hFFFF_FFFF, 32'h10);
        chk("um_dividend", div_dividend, 32'hFFFF_FFFF);
        wait_done(cyc);
        chk("um_lo", lo, 32'h0FFF_FFFF);
        chk("um_hi", hi, 32'hF);

        // Signed -100 / 7
        issue(1'b1, 32'hFFFF_FF9C, 32'd7);
        chk("s1_dividend", div_dividend, 32'd100);
        chk("s1_divisor", div_divisor, 32'd7);
        wait_done(cyc);
        chk("s1_lo", lo, 32'hFFFF_FFF2);
        chk("s1_hi", hi, 32'hFFFF_FFFE);

        // Signed 100 / -7
        issue(1'b1, 32'd100, 32'hFFFF_FFF9);
        chk("s2_divisor", div_divisor, 32'd7);
        wait_done(cyc);
        chk("s2_lo", lo, 32'hFFFF_FFF2);
        chk("s2_hi", hi, 32'd2);

        // Signed -2^31 / -1 wraps
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'h0);
        chk("ovf_dz", {31'b0, dz}, 32'h0);

        // Move-to writes
        mthi = 1'b1; wr_data = 32'hDEAD_BEEF;
        tick();
        mthi = 1'b0;
        chk("mthi", hi, 32'hDEAD_BEEF);
        mtlo = 1'b1; wr_data = 32'h1;
        tick();
        mtlo = 1'b0;
        chk("mtlo", lo, 32'h1);
        chk("mtlo_hi_keep", hi, 32'hDEAD_BEEF);
        mthi = 1'b1; mtlo = 1'b1; wr_data = 32'h77;
        tick();
        chk("mt_both_hi", hi, 32'h77);
        chk("mt_both_lo", lo, 32'h77);
        mtlo = 1'b0; wr_data = 32'h55;
        tick();
        mthi = 1'b0; mtlo = 1'b1; wr_data = 32'hAA;
        tick();
        mtlo = 1'b0;

        // Divide by zero
        issue(1'b0, 32'd5, 32'd0);
        chk("dz_set", {31'b0, dz}, 32'h1);
        chk("dz_busy", {31'b0, busy}, 32'h0);
        tick();
        chk("dz_busy2", {31'b0, busy}, 32'h0);
        chk("dz_hi", hi, 32'h55);
        chk("dz_lo", lo, 32'hAA);
        chk("dz_sticky", {31'b0, dz}, 32'h1);
        issue(1'b0, 32'd9, 32'd2);
        chk("dz_clear", {31'b0, dz}, 32'h0);
        wait_done(cyc);
        chk("dz_next_lo", lo, 32'd4);
        chk("dz_next_hi", hi, 32'd1);

        // Busy interlocks: second start and mtlo during SETTLE are ignored
        issue(1'b0, 32'd100, 32'd7);
        start = 1'b1; op_a = 32'd50; op_b = 32'd3; mtlo = 1'b1; wr_data = 32'h1234;
        tick();
        start = 1'b0; mtlo = 1'b0;
        chk("lock_dividend", div_dividend, 32'd100);
        chk("lock_lo_mid", lo, 32'd4);
        wait_done(cyc);
        chk("lock_lo", lo, 32'd14);
        chk("lock_hi", hi, 32'd2);
        tick();
        chk("lock_no_queue", {31'b0, busy}, 32'h0);

        // Same-cycle start + mthi: start wins
        start = 1'b1; op_a = 32'd23; op_b = 32'd5; mthi = 1'b1; wr_data = 32'hDEAD_0000;
        tick();
        start = 1'b0; mthi = 1'b0;
        chk("sm_hi_mid", hi, 32'd2);
        wait_done(cyc);
        chk("sm_hi", hi, 32'd3);
        chk("sm_lo", lo, 32'd4);

        // Reset clears sticky dz without a clock edge
        issue(1'b0, 32'd1, 32'd0);
        chk("rdz_set", {31'b0, dz}, 32'h1);
        clr = 1'b0;
        #1;
        chk("rdz_clear", {31'b0, dz}, 32'h0);
        clr = 1'b1;
        tick();

        // Asynchronous reset mid-SETTLE
        issue(1'b0, 32'd100, 32'd7);
        tick();
        clr = 1'b0;
        #1;
        chk("rs_busy", {31'b0, busy}, 32'h0);
        chk("rs_hi", hi, 32'h0);
        chk("rs_lo", lo, 32'h0);
        chk("rs_dividend", div_dividend, 32'h0);
        clr = 1'b1;
        tick();
        tick();
        chk("rs_abandon_lo", lo, 32'h0);
        issue(1'b0, 32'd100, 32'd7);
        wait_done(cyc);
        chk("rs_next_cycles", cyc, L + 1);
        chk("rs_next_lo", lo, 32'd14);
        chk("rs_next_hi", hi, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
